// File: rtl/mmu_memory_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mmu_memory_pipe
// Purpose  : In-order request FIFO between the MMU and the memory bus, with
//            outstanding-read tracking and a 2-entry 64-bit return buffer.
// Option   : MMU_MEMORY_PIPE_ALIGN_CHECK_EN enables push-time alignment check
//            (misaligned requests dropped, oERR_VALID pulses one cycle later).
// Revision : 1.0 - initial release
// ============================================================================
module mmu_memory_pipe #(
  parameter int REQ_DEPTH       = 4,
  parameter int REQ_DEPTH_N     = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  // MMU request side
  input  logic        iMMU_REQ,
  output logic        oMMU_LOCK,
  input  logic        iMMU_DATA_STORE_ACK,
  input  logic        iMMU_MMU_USE,
  input  logic [1:0]  iMMU_ORDER,
  input  logic        iMMU_RW,
  input  logic [31:0] iMMU_ADDR,
  input  logic [31:0] iMMU_DATA,
  // MMU return side
  output logic        oMMU_VALID,
  input  logic        iMMU_LOCK,
  output logic [63:0] oMMU_DATA,
  // Memory bus request side
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic        oMEM_DATA_STORE_ACK,
  output logic        oMEM_MMU_USE,
  output logic        oMEM_RW,
  output logic [1:0]  oMEM_ORDER,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  // Memory bus return side
  input  logic        iMEM_VALID,
  output logic        oMEM_LOCK,
  input  logic [63:0] iMEM_DATA,
  // Alignment error pulse
  output logic        oERR_VALID
);

  // Entry layout: {store_ack, mmu_use, order[1:0], rw, addr[31:0], data[31:0]}
  localparam int                   ENTRY_W  = 69;
  localparam logic [REQ_DEPTH_N:0] CNT_FULL = (REQ_DEPTH_N+1)'(REQ_DEPTH);
  localparam logic [REQ_DEPTH_N:0] CNT_HIGH = (REQ_DEPTH_N+1)'(REQ_DEPTH - 1);
  localparam logic [3:0]           OUT_MAX  = 4'(MAX_OUTSTANDING);

  // Request FIFO state
  logic [ENTRY_W-1:0]     r_req_mem [REQ_DEPTH];
  logic [REQ_DEPTH_N-1:0] r_wr_ptr;
  logic [REQ_DEPTH_N-1:0] r_rd_ptr;
  logic [REQ_DEPTH_N:0]   r_count;

  // Reads issued to the bus but not yet returned
  logic [3:0]             r_outstanding;

  // Return buffer state
  logic [63:0]            r_rb_mem [2];
  logic                   r_rb_wr;
  logic                   r_rb_rd;
  logic [1:0]             r_rb_count;

  logic [ENTRY_W-1:0]     w_head;
  logic                   w_head_read;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_issue_read;
  logic                   w_ret_push;
  logic                   w_ret_pop;

  // Lock one entry early so a request launched the cycle lock rises still fits
  assign oMMU_LOCK   = (r_count >= CNT_HIGH) || iMEM_LOCK;
  assign w_accept    = iMMU_REQ && !oMMU_LOCK;

`ifdef MMU_MEMORY_PIPE_ALIGN_CHECK_EN
  logic w_misaligned;
  logic r_err;

  assign w_misaligned = ((iMMU_ORDER == 2'd1) && iMMU_ADDR[0])            ||
                        ((iMMU_ORDER == 2'd2) && (iMMU_ADDR[1:0] != 2'b00)) ||
                        (iMMU_ORDER == 2'd3);
  assign w_push       = w_accept && (r_count != CNT_FULL) && !w_misaligned;
  assign oERR_VALID   = r_err;

  // One-cycle error pulse following a rejected misaligned push
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && w_misaligned;
    end
  end
`else
  assign w_push     = w_accept && (r_count != CNT_FULL);
  assign oERR_VALID = 1'b0;
`endif

  // Head entry drives the bus; a read at the outstanding limit must wait
  assign w_head       = r_req_mem[r_rd_ptr];
  assign w_head_read  = !w_head[64];
  assign oMEM_REQ     = (r_count != '0) && !(w_head_read && (r_outstanding == OUT_MAX));
  assign w_pop        = oMEM_REQ && !iMEM_LOCK;
  assign w_issue_read = w_pop && w_head_read;

  assign oMEM_DATA_STORE_ACK = w_head[68];
  assign oMEM_MMU_USE        = w_head[67];
  assign oMEM_ORDER          = w_head[66:65];
  assign oMEM_RW             = w_head[64];
  assign oMEM_ADDR           = w_head[63:32];
  assign oMEM_DATA           = w_head[31:0];

  // Returns with nothing outstanding are spurious and discarded entirely
  assign oMEM_LOCK  = (r_rb_count == 2'd2);
  assign w_ret_push = iMEM_VALID && !oMEM_LOCK && (r_outstanding != 4'd0);
  assign oMMU_VALID = (r_rb_count != 2'd0);
  assign oMMU_DATA  = r_rb_mem[r_rb_rd];
  assign w_ret_pop  = oMMU_VALID && !iMMU_LOCK;

  // Request FIFO storage, pointers and occupancy
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < REQ_DEPTH; i++) begin
        r_req_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_req_mem[r_wr_ptr] <= {iMMU_DATA_STORE_ACK, iMMU_MMU_USE, iMMU_ORDER,
                                iMMU_RW, iMMU_ADDR, iMMU_DATA};
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Outstanding reads: +1 per read issued, -1 per accepted return
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_outstanding <= 4'd0;
    end else begin
      case ({w_issue_read, w_ret_push})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Two-entry return buffer toward the MMU
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_rb_mem[0] <= '0;
      r_rb_mem[1] <= '0;
      r_rb_wr     <= 1'b0;
      r_rb_rd     <= 1'b0;
      r_rb_count  <= 2'd0;
    end else begin
      if (w_ret_push) begin
        r_rb_mem[r_rb_wr] <= iMEM_DATA;
        r_rb_wr           <= ~r_rb_wr;
      end
      if (w_ret_pop) begin
        r_rb_rd <= ~r_rb_rd;
      end
      case ({w_ret_push, w_ret_pop})
        2'b10:   r_rb_count <= r_rb_count + 2'd1;
        2'b01:   r_rb_count <= r_rb_count - 2'd1;
        default: r_rb_count <= r_rb_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmu_memory_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmu_memory_pipe
// Purpose  : Directed and random checks of mmu_memory_pipe against a
//            queue-based reference model (honours MMU_MEMORY_PIPE_ALIGN_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmu_memory_pipe;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 4;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        mmu_req, sa, mu, rw, mmu_lock_in, mem_lock_in, mem_valid;
  logic [1:0]  order;
  logic [31:0] addr, wdata;
  logic [63:0] mem_rdata;

  logic        oMMU_LOCK, oMMU_VALID, oMEM_REQ, oMEM_DATA_STORE_ACK, oMEM_MMU_USE;
  logic        oMEM_RW, oMEM_LOCK, oERR_VALID;
  logic [1:0]  oMEM_ORDER;
  logic [31:0] oMEM_ADDR, oMEM_DATA;
  logic [63:0] oMMU_DATA;

  int errors = 0;
  int checks = 0;

  always #5 iCLOCK = ~iCLOCK;

  mmu_memory_pipe #(.REQ_DEPTH(DEPTH), .REQ_DEPTH_N(2), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iMMU_REQ(mmu_req), .oMMU_LOCK(oMMU_LOCK),
    .iMMU_DATA_STORE_ACK(sa), .iMMU_MMU_USE(mu), .iMMU_ORDER(order),
    .iMMU_RW(rw), .iMMU_ADDR(addr), .iMMU_DATA(wdata),
    .oMMU_VALID(oMMU_VALID), .iMMU_LOCK(mmu_lock_in), .oMMU_DATA(oMMU_DATA),
    .oMEM_REQ(oMEM_REQ), .iMEM_LOCK(mem_lock_in),
    .oMEM_DATA_STORE_ACK(oMEM_DATA_STORE_ACK), .oMEM_MMU_USE(oMEM_MMU_USE),
    .oMEM_RW(oMEM_RW), .oMEM_ORDER(oMEM_ORDER), .oMEM_ADDR(oMEM_ADDR),
    .oMEM_DATA(oMEM_DATA),
    .iMEM_VALID(mem_valid), .oMEM_LOCK(oMEM_LOCK), .iMEM_DATA(mem_rdata),
    .oERR_VALID(oERR_VALID)
  );

  // Reference model: plain queues of pending requests and buffered returns
  typedef struct packed {
    logic        sa;
    logic        mu;
    logic [1:0]  ord;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  req_t        req_q[$];
  logic [63:0] ret_q[$];
  int          outstanding = 0;
  logic        err_exp = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic misaligned(input logic [1:0] o, input logic [31:0] a);
`ifdef MMU_MEMORY_PIPE_ALIGN_CHECK_EN
    return (o == 2'd3) || (o == 2'd2 && a[1:0] != 2'b00) || (o == 2'd1 && a[0]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_mmu_lock();
    return (req_q.size() >= DEPTH - 1) || mem_lock_in;
  endfunction

  function automatic logic exp_mem_req();
    if (req_q.size() == 0) return 1'b0;
    return !(req_q[0].rw == 1'b0 && outstanding == MAX_OUT);
  endfunction

  task automatic check_model();
    check("mmu_lock", 64'(oMMU_LOCK), 64'(exp_mmu_lock()));
    check("mem_req", 64'(oMEM_REQ), 64'(exp_mem_req()));
    if (req_q.size() > 0) begin
      check("mem_addr", 64'(oMEM_ADDR), 64'(req_q[0].addr));
      check("mem_data", 64'(oMEM_DATA), 64'(req_q[0].data));
      check("mem_fields", 64'({oMEM_DATA_STORE_ACK, oMEM_MMU_USE, oMEM_ORDER, oMEM_RW}),
            64'({req_q[0].sa, req_q[0].mu, req_q[0].ord, req_q[0].rw}));
    end
    check("mem_lock", 64'(oMEM_LOCK), 64'(ret_q.size() == 2));
    check("mmu_valid", 64'(oMMU_VALID), 64'(ret_q.size() > 0));
    if (ret_q.size() > 0) check("mmu_data", oMMU_DATA, ret_q[0]);
    check("err_valid", 64'(oERR_VALID), 64'(err_exp));
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic update_model();
    logic accept, pop, rpush, rpop, bad;
    accept = mmu_req && !exp_mmu_lock();
    pop    = exp_mem_req() && !mem_lock_in;
    rpush  = mem_valid && ret_q.size() < 2 && outstanding > 0;
    rpop   = ret_q.size() > 0 && !mmu_lock_in;
    bad    = misaligned(order, addr);
    if (pop) begin
      if (req_q[0].rw == 1'b0) outstanding++;
      void'(req_q.pop_front());
    end
    if (rpop) void'(ret_q.pop_front());
    if (rpush) begin
      ret_q.push_back(mem_rdata);
      outstanding--;
    end
    if (accept && !bad) req_q.push_back('{sa, mu, order, rw, addr, wdata});
    err_exp = accept && bad;
  endtask

  task automatic tick();
    #1;
    check_model();
    update_model();
    @(negedge iCLOCK);
  endtask

  task automatic idle();
    mmu_req = 0; sa = 0; mu = 0; order = 0; rw = 0; addr = 0; wdata = 0;
    mmu_lock_in = 0; mem_lock_in = 0; mem_valid = 0; mem_rdata = 0;
  endtask

  task automatic set_req(input logic r_w, input logic [31:0] a, input logic [31:0] d);
    mmu_req = 1; rw = r_w; addr = a; wdata = d; order = 2'd2; sa = r_w; mu = 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs1"}, 64'({oMMU_LOCK, oMMU_VALID, oMEM_REQ, oMEM_DATA_STORE_ACK,
                                oMEM_MMU_USE, oMEM_RW, oMEM_LOCK, oERR_VALID, oMEM_ORDER}), 64'd0);
    check({tag, "_addr"}, 64'(oMEM_ADDR), 64'd0);
    check({tag, "_wdata"}, 64'(oMEM_DATA), 64'd0);
    check({tag, "_rdata"}, oMMU_DATA, 64'd0);
  endtask

  initial begin
    idle();
    inRESET = 1'b0;
    @(negedge iCLOCK);
    #1 check_all_zero("reset");
    @(negedge iCLOCK);
    inRESET = 1'b1;

    // Single read: visible on the bus the cycle after push, return the cycle after valid
    set_req(1'b0, 32'h0000_1000, 32'h0);
    tick();
    check("sr_req", 64'(oMEM_REQ), 64'd1);
    check("sr_addr", 64'(oMEM_ADDR), 64'h0000_1000);
    idle();
    tick();
    mem_valid = 1; mem_rdata = 64'h1122_3344_5566_7788;
    tick();
    check("sr_valid", 64'(oMMU_VALID), 64'd1);
    check("sr_data", oMMU_DATA, 64'h1122_3344_5566_7788);
    idle();
    tick();
    check("sr_drained", 64'(oMMU_VALID), 64'd0);

    // Outstanding limit with a full FIFO behind the stalled read
    for (int i = 0; i < 5; i++) begin
      set_req(1'b0, 32'h0000_2000 + 32'(i * 4), 32'h0);
      tick();
    end
    set_req(1'b1, 32'h0000_3000, 32'hAAAA_0001);
    tick();
    set_req(1'b1, 32'h0000_3004, 32'hAAAA_0002);
    tick();
    check("ol_lock", 64'(oMMU_LOCK), 64'd1);
    check("ol_blocked", 64'(oMEM_REQ), 64'd0);
    check("ol_head", 64'(oMEM_ADDR), 64'h0000_2010);
    idle();
    mmu_lock_in = 1; mem_valid = 1; mem_rdata = 64'hD0D0_D0D0_0000_0001;
    tick();
    check("ol_release", 64'(oMEM_REQ), 64'd1);
    mem_valid = 0;
    tick();
    check("ol_w0", 64'(oMEM_ADDR), 64'h0000_3000);
    tick();
    check("ol_w1", 64'(oMEM_ADDR), 64'h0000_3004);
    tick();
    check("ol_empty", 64'(oMEM_REQ), 64'd0);

    // Return backpressure: buffer fills, extra return dropped, then drains in order
    mem_valid = 1; mem_rdata = 64'hE0E0_E0E0_0000_0002;
    tick();
    check("rb_full", 64'(oMEM_LOCK), 64'd1);
    check("rb_oldest", oMMU_DATA, 64'hD0D0_D0D0_0000_0001);
    mem_rdata = 64'hF0F0_F0F0_0000_0003;
    tick();
    idle();
    tick();
    check("rb_second", oMMU_DATA, 64'hE0E0_E0E0_0000_0002);
    check("rb_unlock", 64'(oMEM_LOCK), 64'd0);
    tick();
    check("rb_empty", 64'(oMMU_VALID), 64'd0);

    // Reset with requests queued and reads outstanding
    for (int i = 0; i < 3; i++) begin
      set_req(1'b0, 32'h0000_4000 + 32'(i * 4), 32'h0);
      tick();
    end
    idle();
    #2 inRESET = 1'b0;
    #1 check_all_zero("midrst");
    req_q.delete(); ret_q.delete(); outstanding = 0; err_exp = 1'b0;
    @(negedge iCLOCK);
    inRESET = 1'b1;
    mem_valid = 1; mem_rdata = 64'h5555_5555_5555_5555;
    tick();
    idle();
    tick();
    check("midrst_ignored", 64'(oMMU_VALID), 64'd0);

`ifdef MMU_MEMORY_PIPE_ALIGN_CHECK_EN
    set_req(1'b0, 32'h0000_1002, 32'h0);
    tick();
    check("align_err", 64'(oERR_VALID), 64'd1);
    check("align_noreq", 64'(oMEM_REQ), 64'd0);
    idle();
    tick();
    check("align_pulse", 64'(oERR_VALID), 64'd0);
`endif

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      mmu_req     = ($urandom_range(0, 1) == 1);
      sa          = 1'($urandom);
      mu          = 1'($urandom);
      order       = 2'($urandom);
      rw          = 1'($urandom);
      addr        = $urandom;
      wdata       = $urandom;
      mem_lock_in = ($urandom_range(0, 3) == 0);
      mmu_lock_in = ($urandom_range(0, 9) < 3);
      mem_valid   = ($urandom_range(0, 9) < 4);
      mem_rdata   = {$urandom, $urandom};
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
